// File: rtl/mealy_pkg.sv
// Shared helpers for the Mealy sequence detector: KMP-style transition and
// failure functions evaluated at elaboration time, plus the state-width rule.
package mealy_pkg;

    localparam int MAX_PATTERN_W = 16;

    // State register width for a pattern of the given length (legal range 2..16).
    function automatic int state_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Bit idx of a pattern word, using a shift so the index needs no width cast.
    function automatic logic bit_at(input logic [MAX_PATTERN_W-1:0] pattern, input int idx);
        logic [MAX_PATTERN_W-1:0] sh;
        sh = pattern >> idx;
        return sh[0];
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    // Received-order position m corresponds to pattern bit width-1-m.
    function automatic int fail_len(input logic [MAX_PATTERN_W-1:0] pattern, input int width);
        logic ok;
        for (int j = width - 1; j > 0; j--) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (bit_at(pattern, width - 1 - i) != bit_at(pattern, j - 1 - i))
                    ok = 1'b0;
            end
            if (ok)
                return j;
        end
        return 0;
    endfunction

    // Next state from state k on input bit b. A completed match goes to the
    // overlap fallback or to 0; otherwise the longest pattern prefix that is a
    // suffix of (first k pattern bits followed by b), capped below width.
    function automatic int next_state(input logic [MAX_PATTERN_W-1:0] pattern, input int width,
                                      input int state, input logic b, input logic overlap);
        int   m;
        int   top;
        logic s_m;
        logic ok;
        if (state == width - 1 && b == bit_at(pattern, width - 1 - state))
            return overlap ? fail_len(pattern, width) : 0;
        top = (state + 1 < width - 1) ? state + 1 : width - 1;
        for (int j = top; j > 0; j--) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                m   = state + 1 - j + i;
                s_m = (m < state) ? bit_at(pattern, width - 1 - m) : b;
                if (s_m != bit_at(pattern, width - 1 - i))
                    ok = 1'b0;
            end
            if (ok)
                return j;
        end
        return 0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky saturation flag; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    localparam logic [W-1:0] MAX = '1;

    // Count increments until all-ones, then holds; sat is set on reaching all-ones.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset || clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc) begin
            if (count != MAX)
                count <= count + 1'b1;
            if (count >= MAX - 1'b1)
                sat <= 1'b1;
        end
    end

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy sequence detector with an elaboration-time KMP transition
// table, combinational match output and a saturating match counter.
module mealy_seq_detector
    import mealy_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter int                   OVERLAP   = 1,
    parameter int                   CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          data_in,
    input  logic                          clr_cnt,
    output logic                          match,
    output logic [state_w(PATTERN_W)-1:0] state_out,
    output logic [CNT_W-1:0]              match_count,
    output logic                          cnt_sat
);

    localparam int SW = state_w(PATTERN_W);
    localparam int NUM_CODES = 2 ** SW;
    localparam logic [MAX_PATTERN_W-1:0] PAT16 = MAX_PATTERN_W'(PATTERN);
    localparam logic OVL = (OVERLAP != 0);

    localparam logic [SW-1:0] S_IDLE = '0;
    localparam logic [SW-1:0] S_LAST = SW'(PATTERN_W - 1);

    logic [SW-1:0] state;
    logic [SW-1:0] trans_tbl [NUM_CODES][2];

    // Constant transition table; unused encodings fall back to the idle state.
    for (genvar k = 0; k < NUM_CODES; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            if (k < PATTERN_W) begin : g_legal
                assign trans_tbl[k][b] = SW'(next_state(PAT16, PATTERN_W, k, (b != 0), OVL));
            end else begin : g_unused
                assign trans_tbl[k][b] = S_IDLE;
            end
        end
    end

    // Mealy output: final pattern bit presented while in the last state.
    assign match = en & ~reset & (state == S_LAST) & (data_in == PATTERN[0]);

    // State register advances only on enabled samples; reset discards progress.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else if (en)
            state <= trans_tbl[state][data_in];
    end

    assign state_out = state;

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_cnt),
        .inc  (match),
        .count(match_count),
        .sat  (cnt_sat)
    );

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed testbench for mealy_seq_detector: three instances share the
// stimulus (overlap/8-bit counter, non-overlap, overlap/2-bit counter).
module tb_mealy_seq_detector;

    logic clk = 1'b0;
    logic reset, en, data_in, clr_cnt;

    logic       match_a, match_b, match_c;
    logic [1:0] state_a, state_b, state_c;
    logic [7:0] count_a, count_b;
    logic [1:0] count_c;
    logic       sat_a, sat_b, sat_c;

    logic m_a, m_b, m_c;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mealy_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
        .match(match_a), .state_out(state_a), .match_count(count_a), .cnt_sat(sat_a));

    mealy_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
        .match(match_b), .state_out(state_b), .match_count(count_b), .cnt_sat(sat_b));

    mealy_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
        .match(match_c), .state_out(state_c), .match_count(count_c), .cnt_sat(sat_c));

    // Drive one sample at the falling edge, capture the Mealy outputs mid-cycle,
    // then let the rising edge update state and sample 1 ns after it.
    task automatic step(input logic d, input logic e, input logic c);
        @(negedge clk);
        data_in = d;
        en      = e;
        clr_cnt = c;
        #1;
        m_a = match_a;
        m_b = match_b;
        m_c = match_c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b0; data_in = 1'b0; clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b1; data_in = 1'b1; clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (state_a !== 2'd0 || count_a !== 8'd0 || sat_a !== 1'b0 || match_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_a: state=%0d count=%0d sat=%b match=%b, required 0 0 0 0",
                     state_a, count_a, sat_a, match_a);
        end
        checks++;
        if (state_c !== 2'd0 || count_c !== 2'd0 || sat_c !== 1'b0) begin
            fails++;
            $display("FAIL reset_c: state=%0d count=%0d sat=%b, required 0 0 0",
                     state_c, count_c, sat_c);
        end
        reset = 1'b0;
    endtask

    // Stream 1011011: overlap vs non-overlap behaviour.
    task automatic test_overlap();
        logic [0:6] bits  = 7'b1011011;
        logic [0:6] exp_ma = 7'b0001001;
        logic [0:6] exp_mb = 7'b0001000;
        int exp_sa [7] = '{1, 2, 3, 1, 2, 3, 1};
        int exp_sb [7] = '{1, 2, 3, 0, 0, 1, 1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(bits[i], 1'b1, 1'b0);
            checks++;
            if (m_a !== exp_ma[i] || state_a !== 2'(exp_sa[i])) begin
                fails++;
                $display("FAIL overlap_bit%0d: match=%b state=%0d, required %b %0d",
                         i + 1, m_a, state_a, exp_ma[i], exp_sa[i]);
            end
            checks++;
            if (m_b !== exp_mb[i] || state_b !== 2'(exp_sb[i])) begin
                fails++;
                $display("FAIL no_overlap_bit%0d: match=%b state=%0d, required %b %0d",
                         i + 1, m_b, state_b, exp_mb[i], exp_sb[i]);
            end
        end
        checks++;
        if (count_a !== 8'd2 || count_b !== 8'd1) begin
            fails++;
            $display("FAIL overlap_counts: a=%0d b=%0d, required 2 1", count_a, count_b);
        end
    endtask

    // Stream 101011: the 101+0 mismatch must fall back to state 2.
    task automatic test_mismatch();
        logic [0:5] bits   = 6'b101011;
        logic [0:5] exp_m  = 6'b000001;
        int exp_s [6] = '{1, 2, 3, 2, 3, 1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(bits[i], 1'b1, 1'b0);
            checks++;
            if (m_a !== exp_m[i] || state_a !== 2'(exp_s[i])) begin
                fails++;
                $display("FAIL mismatch_bit%0d: match=%b state=%0d, required %b %0d",
                         i + 1, m_a, state_a, exp_m[i], exp_s[i]);
            end
        end
    endtask

    // en low holds the state and suppresses match even with the final bit present.
    task automatic test_enable();
        logic [0:3] idle = 4'b1010;
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(idle[i], 1'b0, 1'b0);
            checks++;
            if (m_a !== 1'b0 || state_a !== 2'd3 || count_a !== 8'd0) begin
                fails++;
                $display("FAIL enable_hold%0d: match=%b state=%0d count=%0d, required 0 3 0",
                         i, m_a, state_a, count_a);
            end
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (m_a !== 1'b1 || state_a !== 2'd1 || count_a !== 8'd1) begin
            fails++;
            $display("FAIL enable_resume: match=%b state=%0d count=%0d, required 1 1 1",
                     m_a, state_a, count_a);
        end
    endtask

    // Five matches saturate the 2-bit counter; clear coincident with a match wins.
    task automatic test_saturation_clear();
        logic [0:3] first = 4'b1011;
        logic [0:2] tail  = 3'b011;
        do_reset();
        for (int i = 0; i < 4; i++)
            step(first[i], 1'b1, 1'b0);
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 3; i++)
                step(tail[i], 1'b1, 1'b0);
        checks++;
        if (count_c !== 2'd3 || sat_c !== 1'b1) begin
            fails++;
            $display("FAIL saturate: count=%0d sat=%b, required 3 1", count_c, sat_c);
        end
        checks++;
        if (count_a !== 8'd5 || sat_a !== 1'b0) begin
            fails++;
            $display("FAIL wide_count: count=%0d sat=%b, required 5 0", count_a, sat_a);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (m_c !== 1'b1 || count_c !== 2'd0 || sat_c !== 1'b0 || state_c !== 2'd1) begin
            fails++;
            $display("FAIL clear_on_match: match=%b count=%0d sat=%b state=%0d, required 1 0 0 1",
                     m_c, count_c, sat_c, state_c);
        end
        checks++;
        if (count_a !== 8'd0) begin
            fails++;
            $display("FAIL clear_wide: count=%0d, required 0", count_a);
        end
        clr_cnt = 1'b0;
    endtask

    // Reset in state 3 with the final bit present blocks match and discards progress.
    task automatic test_reset_mid();
        logic [0:3] bits  = 4'b1011;
        logic [0:3] exp_m = 4'b0001;
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1; en = 1'b1; data_in = 1'b1;
        #1;
        checks++;
        if (match_a !== 1'b0 || match_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_match: a=%b b=%b, required 0 0", match_a, match_b);
        end
        @(posedge clk);
        #1;
        checks++;
        if (state_a !== 2'd0 || count_a !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_state: state=%0d count=%0d, required 0 0", state_a, count_a);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(bits[i], 1'b1, 1'b0);
            checks++;
            if (m_a !== exp_m[i]) begin
                fails++;
                $display("FAIL after_reset_bit%0d: match=%b, required %b", i + 1, m_a, exp_m[i]);
            end
        end
        checks++;
        if (count_a !== 8'd1) begin
            fails++;
            $display("FAIL after_reset_count: count=%0d, required 1", count_a);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; data_in = 1'b0; clr_cnt = 1'b0;
        test_reset();
        test_overlap();
        test_mismatch();
        test_enable();
        test_saturation_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule

// File: doc/mealy_seq_detector.md
Name: mealy_seq_detector

Overview:
Parametrised Mealy sequence detector for a serial bit stream. It is the successor to the fixed 4-state Mealy machine. Pattern, pattern length, overlap mode and counter width are all parameters. The match output is Mealy: it depends on the current state and the current input, with no clock edge in between. A saturating match counter and an enable/clear interface let the block sit between a serial front end and a status register.

Parameters:
PATTERN_W, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b1011, target sequence; bit PATTERN_W-1 is received first, bit 0 last.
OVERLAP, 1, 1 = overlapping matches allowed, 0 = detector restarts from empty after each match.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
en  input  1  sample-valid; data_in is consumed only on cycles where en=1.
data_in  input  1  serial input bit.
clr_cnt  input  1  synchronous clear of match_count and cnt_sat.
match  output  1  Mealy match: high in the same cycle the final pattern bit is presented.
state_out  output  $clog2(PATTERN_W)  current state (number of pattern bits matched so far).
match_count  output  CNT_W  saturating count of matches.
cnt_sat  output  1  sticky flag; set when match_count reaches all-ones.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high and sampled on the rising edge of clk.
- Reset values: state=0, match_count=0, cnt_sat=0.
- match is forced to 0 while reset=1, regardless of state or data_in.
- State encoding:
  - State k (0..PATTERN_W-1) means the last k consumed bits equal the first k pattern bits.
  - Next-state logic is KMP-style, computed at elaboration from PATTERN. There is no runtime pattern storage.
- Expected bit in state k: exp = PATTERN[PATTERN_W-1-k].
- Transitions, evaluated only when en=1:
  - In state k<PATTERN_W-1 with data_in==exp: go to k+1.
  - On a mismatch: go to the longest j such that the first j pattern bits equal the suffix of (consumed prefix + data_in). This can be 0.
  - In state PATTERN_W-1 with data_in==exp (a match):
    - OVERLAP=1: go to fail(PATTERN_W), the longest proper prefix of PATTERN that is also a suffix.
    - OVERLAP=0: go to 0.
- match = en & ~reset & (state==PATTERN_W-1) & (data_in==PATTERN[0]). This is purely combinational, with zero latency, and may glitch as data_in changes.
- en=0: state, match_count and cnt_sat hold; match=0.
- Counter:
  - On each cycle with match=1, match_count increments on the same clk edge that updates state.
  - At all-ones the counter holds and cnt_sat is set. cnt_sat stays set until clr_cnt or reset.
- Simultaneous events:
  - reset has priority over everything.
  - When clr_cnt and match occur in the same cycle, match_count becomes 0 and the match is not counted. The state still advances normally.
- Reset mid-sequence: partial progress is discarded. The first bit after reset is evaluated from state 0.

Decomposition:
- Package mealy_pkg holds:
  - an elaboration-time function next_state(pattern, width, state, bit, overlap) returning the KMP transition;
  - a function fail_len(pattern, width);
  - a localparam helper for the state width.
- The top module builds a constant transition table (generate/function) plus the state register.
- One sub-module, sat_counter (parameter W; ports clk, reset, clr, inc, count, sat), implements the saturating counter with clr priority over inc.

Test Plan:
1. PATTERN=4'b1011, OVERLAP=1, en=1. Stream 1,0,1,1,0,1,1 -> match high on bits 4 and 7 only; state after bit 4 is 1; match_count=2.
2. Same stream with OVERLAP=0 -> match high on bit 4 only. State sequence after the match: 0,1,1. match_count=1.
3. Mismatch fallback: stream 1,0,1,0,1,1 -> states 1,2,3,2,3, then match on bit 6. Checks the 101+0 -> "10" transition.
4. en gating: stream 1,0,1 with en=1, then 4 cycles of en=0 with data_in toggling, then 1 with en=1 -> state held at 3 during en=0, match=0 throughout; match=1 on the final bit.
5. Saturation/clear, CNT_W=2: 5 matches -> match_count=3, cnt_sat=1. Then clr_cnt in the same cycle as a match -> match_count=0, cnt_sat=0, state still advances.
6. Reset mid-operation: drive to state 3, then assert reset with data_in=1 -> match=0 that cycle, state=0 next cycle, match_count=0. A following stream 1,0,1,1 -> a single match on bit 4.
